// File: rtl/q16_mul_arbiter.sv
// q16_mul_arbiter: round-robin share of one pipelined signed Q16.16
// multiplier among N_REQ requesters, with in-order tagged responses.
//
// Ports:
//   clk, rst    - rising-edge clock, async active-high reset
//   req_valid   - per-requester operand valid      [N_REQ]
//   req_ready   - per-requester grant, one-hot/0   [N_REQ]
//   req_a/req_b - packed Q16.16 operands, 32 bits per requester
//   rsp_valid   - response head valid
//   rsp_ready   - consumer accepts head
//   rsp_data    - Q16.16 product
//   rsp_id      - issuing requester index
//   rsp_sat     - head result was clamped
//   busy        - any operation in pipeline or response FIFO
//
// Build option: define Q16_MUL_SAT_EN to clamp overflowing products and
// report rsp_sat; otherwise results wrap and rsp_sat stays 0.

module q16_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MUL_STAGES = 2,
    parameter int RSP_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [32*N_REQ-1:0]      req_a,
    input  logic [32*N_REQ-1:0]      req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_sat,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = $clog2(RSP_DEPTH);
    localparam int CW  = AW + 1;

    // ---------------- credit and arbitration ----------------
    logic [CW-1:0]  outstanding;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           sel_vld;
    logic           credit;
    logic           issue;
    logic           pop;

    // First valid requester after the last granted one, with wrap.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!sel_vld && req_valid[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    // Credit uses the registered count, so a pop frees space one cycle
    // later; rst gates the grant so req_ready drops with the reset.
    assign credit = outstanding < CW'(RSP_DEPTH);
    assign issue  = sel_vld && credit && !rst;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IDW'(N_REQ - 1);
        end else if (issue) begin
            rr_ptr <= sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(pop);
        end
    end

    assign busy = outstanding != '0;

    // ---------------- operand capture ----------------
    logic           s0_vld;
    logic [31:0]    s0_a;
    logic [31:0]    s0_b;
    logic [IDW-1:0] s0_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld <= 1'b0;
            s0_a   <= '0;
            s0_b   <= '0;
            s0_id  <= '0;
        end else begin
            s0_vld <= issue;
            if (issue) begin
                s0_a  <= req_a[int'(sel)*32 +: 32];
                s0_b  <= req_b[int'(sel)*32 +: 32];
                s0_id <= sel;
            end
        end
    end

    // ---------------- multiply and result format ----------------
    logic signed [63:0] prod;
    logic [31:0]        m_res;
    logic               m_sat;
    logic               unused_prod;

    assign prod = 64'($signed(s0_a)) * 64'($signed(s0_b));
    assign unused_prod = ^{prod[63:48], prod[15:0]};

`ifdef Q16_MUL_SAT_EN
    // Product fits Q16.16 only when bits 63..47 are a pure sign extension.
    logic m_ovf;
    assign m_ovf = !((&prod[63:47]) || !(|prod[63:47]));

    always_comb begin
        m_res = prod[47:16];
        m_sat = m_ovf;
        if (m_ovf) begin
            m_res = prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    always_comb begin
        m_res = prod[47:16];
        m_sat = 1'b0;
    end
`endif

    // ---------------- result pipeline ----------------
    logic           st_vld  [MUL_STAGES];
    logic [31:0]    st_data [MUL_STAGES];
    logic [IDW-1:0] st_id   [MUL_STAGES];
    logic           st_sat  [MUL_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < MUL_STAGES; s++) begin
                st_vld[s]  <= 1'b0;
                st_data[s] <= '0;
                st_id[s]   <= '0;
                st_sat[s]  <= 1'b0;
            end
        end else begin
            st_vld[0]  <= s0_vld;
            st_data[0] <= m_res;
            st_id[0]   <= s0_id;
            st_sat[0]  <= m_sat;
            for (int s = 1; s < MUL_STAGES; s++) begin
                st_vld[s]  <= st_vld[s-1];
                st_data[s] <= st_data[s-1];
                st_id[s]   <= st_id[s-1];
                st_sat[s]  <= st_sat[s-1];
            end
        end
    end

    // ---------------- response FIFO ----------------
    logic [31:0]    f_data [RSP_DEPTH];
    logic [IDW-1:0] f_id   [RSP_DEPTH];
    logic           f_sat  [RSP_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           push;

    // Credit guarantees space, so the last stage writes unconditionally.
    assign push = st_vld[MUL_STAGES-1];

    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr[AW-1:0]] <= st_data[MUL_STAGES-1];
            f_id[wr_ptr[AW-1:0]]   <= st_id[MUL_STAGES-1];
            f_sat[wr_ptr[AW-1:0]]  <= st_sat[MUL_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rsp_valid = wr_ptr != rd_ptr;
    assign pop       = rsp_valid && rsp_ready;

    // Gate the head with valid so outputs read zero when empty/reset.
    assign rsp_data = rsp_valid ? f_data[rd_ptr[AW-1:0]] : '0;
    assign rsp_id   = rsp_valid ? f_id[rd_ptr[AW-1:0]] : '0;
    assign rsp_sat  = rsp_valid && f_sat[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_q16_mul_arbiter.sv
// tb_q16_mul_arbiter: randomized and directed checks of q16_mul_arbiter
// against a transaction-level reference model.

module tb_q16_mul_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_sat;
    logic           busy;

    q16_mul_arbiter #(
        .N_REQ(N),
        .MUL_STAGES(2),
        .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_id(rsp_id),
        .rsp_sat(rsp_sat),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product: {sat, result} from plain 64-bit arithmetic.
    function automatic logic [32:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [63:0] r;
        logic signed [63:0] lim;
        logic ov;
        p   = 64'($signed(a)) * 64'($signed(b));
        r   = p >>> 16;
        lim = 64'sd1 <<< 47;
        ov  = (p >= lim) || (p < -lim);
`ifdef Q16_MUL_SAT_EN
        if (ov) begin
            return {1'b1, (p < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        return {1'b0, r[31:0]};
`else
        if (ov) begin
            return {1'b0, r[31:0]};
        end
        return {1'b0, r[31:0]};
`endif
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(3))
            0: return v;
            1: return {{12{v[19]}}, v[19:0]};
            2: return v[31] ? (32'h7FFF_0000 | (v & 32'hFFFF))
                            : (32'h8000_0000 | (v & 32'hFFFF));
            default: return {{8{v[23]}}, v[23:0]};
        endcase
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic [1:0]  id;
        logic        s;
        int          avail;
    } exp_t;

    exp_t       q[$];
    int         cyc    = 0;
    int         m_last = N - 1;
    int         m_out  = 0;
    logic [N-1:0] hs_mask = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int g;
        int i;
        logic [N-1:0] exp_rdy;
        logic exp_v;
        logic pop;
        logic [32:0] r;
        exp_t e;
        if (rst) begin
            q.delete();
            m_out   = 0;
            m_last  = N - 1;
            hs_mask = '0;
        end else begin
            g = -1;
            if (m_out < DEPTH) begin
                for (int k = 1; k <= N; k++) begin
                    i = (m_last + k) % N;
                    if (g < 0 && req_valid[i]) g = i;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_out != 0);
            exp_v = q.size() > 0 && q[0].avail <= cyc;
            chk("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                chk("rsp_data", rsp_data, q[0].d);
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_sat", rsp_sat, q[0].s);
            end
            pop = exp_v && rsp_ready;
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                r       = ref_mul(req_a[32*g +: 32], req_b[32*g +: 32]);
                e.d     = r[31:0];
                e.s     = r[32];
                e.id    = 2'(g);
                e.avail = cyc + LAT + 1;
                q.push_back(e);
                m_last = g;
            end
            m_out   = m_out + (g >= 0 ? 1 : 0) - (pop ? 1 : 0);
            hs_mask = exp_rdy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) step();
    endtask

    // Requesters keep valid and operands until granted, then redraw.
    task automatic drive_all(input int pv);
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || hs_mask[i]) begin
                req_valid[i] = $urandom_range(99) < pv;
                req_a[32*i +: 32] = rand_op();
                req_b[32*i +: 32] = rand_op();
            end
        end
    endtask

    task automatic single_op(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_d,
                             input logic exp_s);
        int n;
        logic got;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a[31:0] = a;
        req_b[31:0] = b;
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = hs_mask[0];
        end
        req_valid[0] = 1'b0;
        chk({tag, "_grant"}, got, 1'b1);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_id"}, rsp_id, 2'd0);
        chk({tag, "_sat"}, rsp_sat, exp_s);
        repeat (4) step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int hs;
        int guard;
        logic [31:0] ov_d;
        logic ov_s;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #3;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_rsp_sat", rsp_sat, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        single_op("mul_1p5x2", 32'h0001_8000, 32'h0002_0000,
                  32'h0003_0000, 1'b0);
        single_op("mul_neg", 32'hFFFD_8000, 32'h0004_0000,
                  32'hFFF6_0000, 1'b0);
        single_op("mul_negneg", 32'hFFFF_0000, 32'hFFFF_0000,
                  32'h0001_0000, 1'b0);
`ifdef Q16_MUL_SAT_EN
        ov_d = 32'h7FFF_FFFF;
        ov_s = 1'b1;
`else
        ov_d = 32'hFFFE_0000;
        ov_s = 1'b0;
`endif
        single_op("mul_ovf", 32'h7FFF_0000, 32'h0002_0000, ov_d, ov_s);

        // Fairness: everyone requests, one grant per cycle.
        drain();
        req_valid = '0;
        hs = 0;
        for (int c = 0; c < 24; c++) begin
            drive_all(100);
            step();
            hs += $countones(hs_mask);
        end
        chk("fair_hs_count", hs, 24);

        // Backpressure: consumer stalls, exactly DEPTH issues fit.
        drain();
        rsp_ready = 1'b0;
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            drive_all(100);
            step();
            hs += $countones(hs_mask);
        end
        chk("bp_hs_count", hs, DEPTH);
        chk("bp_req_ready", req_ready, '0);
        chk("bp_busy", busy, 1'b1);
        chk("bp_queued", q.size(), DEPTH);
        rsp_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            drive_all(100);
            step();
            hs += $countones(hs_mask);
        end
        chk("bp_resume", hs > 0, 1'b1);

        // Random traffic with random consumer stalls.
        drain();
        for (int c = 0; c < 500; c++) begin
            rsp_ready = $urandom_range(99) < ((c / 100) % 2 == 0 ? 70 : 25);
            drive_all(60);
            step();
        end
        drain();
        chk("drain_empty", q.size(), 0);
        chk("drain_busy", busy, 1'b0);

        // Reset with 3 ops in the pipeline and 2 in the FIFO.
        rsp_ready = 1'b0;
        req_valid = '0;
        hs = 0;
        guard = 0;
        while (hs < 5 && guard < 20) begin
            drive_all(100);
            step();
            hs += $countones(hs_mask);
            guard++;
        end
        chk("mid_hs", hs, 5);
        chk("mid_pre_valid", rsp_valid, 1'b1);
        req_valid = '1;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rsp_data", rsp_data, 32'h0);
        chk("mid_rsp_id", rsp_id, 2'd0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_req_ready", req_ready, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("post_no_stale", rsp_valid, 1'b0);
        end
        req_valid = '1;
        #1;
        chk("post_first_grant", req_ready, 4'b0001);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_all(100);
            step();
        end
        drain();
        chk("final_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
